// File: rtl/wave_frame_sched_if.sv
// Scheduler-side bundle: VGA timing/read port on one side, generator stream on the other.
// The master drives sync, reads and samples; the slave is the scheduler.
interface wave_frame_sched_if #(
    parameter int DATA_W = 10
);
    logic              vsync;
    logic              freeze;
    logic [10:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              gen_start;
    logic [DATA_W-1:0] gen_data;
    logic              gen_valid;
    logic              gen_ready;
    logic              swapped;
    logic              front_bank;
    logic [7:0]        frames_missed;

    modport master (
        output vsync, freeze, rd_addr, gen_data, gen_valid,
        input  rd_data, gen_start, gen_ready, swapped, front_bank, frames_missed
    );

    modport slave (
        input  vsync, freeze, rd_addr, gen_data, gen_valid,
        output rd_data, gen_start, gen_ready, swapped, front_bank, frames_missed
    );
endinterface

// File: rtl/wave_frame_sched.sv
// Double-buffered wave-profile store: the display reads the front bank while the generator
// fills the back bank; banks swap on a vsync rise only once the back bank is complete.
module wave_frame_sched #(
    parameter int WIDTH      = 1024,
    parameter int DATA_W     = 10,
    parameter int INIT_LEVEL = 384
) (
    input  logic clock,
    input  logic reset,
    wave_frame_sched_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_START, S_FILL, S_READY} state_t;

    state_t            r_state;
    logic [10:0]       r_wr_idx;
    logic              r_front;
    logic              r_vsync_d;
    logic              r_gen_start;
    logic              r_gen_ready;
    logic              r_swapped;
    logic [7:0]        r_missed;
    logic [DATA_W-1:0] r_rd_data;

    // Power-up content only; reset deliberately leaves the banks alone.
    logic [DATA_W-1:0] r_mem [0:2*WIDTH-1] = '{default: DATA_W'(INIT_LEVEL)};

    logic w_rise;
    logic w_wr_en;
    logic w_miss;
    logic w_rd_hit;
    logic w_swap;

    assign w_rise   = bus.vsync & ~r_vsync_d;
    assign w_wr_en  = (r_state == S_FILL) & bus.gen_valid;
    assign w_swap   = w_rise & (r_state == S_READY) & ~bus.freeze;
    assign w_miss   = w_rise & ~w_swap;
    assign w_rd_hit = (bus.rd_addr < 11'(WIDTH));

    // Back bank is always the complement of the front bank.
    always_ff @(posedge clock) begin
        if (w_wr_en)
            r_mem[{~r_front, r_wr_idx[AW-1:0]}] <= bus.gen_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_START;
            r_wr_idx    <= '0;
            r_front     <= 1'b0;
            r_vsync_d   <= 1'b0;
            r_gen_start <= 1'b1;
            r_gen_ready <= 1'b0;
            r_swapped   <= 1'b0;
            r_missed    <= '0;
            r_rd_data   <= '0;
        end else begin
            r_vsync_d   <= bus.vsync;
            r_swapped   <= 1'b0;
            r_gen_start <= 1'b0;
            r_rd_data   <= w_rd_hit ? r_mem[{r_front, bus.rd_addr[AW-1:0]}] : '0;
            if (w_miss && r_missed != 8'hFF)
                r_missed <= r_missed + 8'd1;
            case (r_state)
                S_START: begin
                    r_wr_idx    <= '0;
                    r_state     <= S_FILL;
                    r_gen_ready <= 1'b1;
                end
                S_FILL: begin
                    if (bus.gen_valid) begin
                        if (r_wr_idx == 11'(WIDTH - 1)) begin
                            r_wr_idx    <= '0;
                            r_state     <= S_READY;
                            r_gen_ready <= 1'b0;
                        end else begin
                            r_wr_idx <= r_wr_idx + 11'd1;
                        end
                    end
                end
                S_READY: begin
                    if (w_swap) begin
                        r_front     <= ~r_front;
                        r_swapped   <= 1'b1;
                        r_gen_start <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                default: begin
                    r_state     <= S_START;
                    r_gen_start <= 1'b1;
                    r_gen_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.gen_start     = r_gen_start;
    assign bus.gen_ready     = r_gen_ready;
    assign bus.swapped       = r_swapped;
    assign bus.front_bank    = r_front;
    assign bus.frames_missed = r_missed;
endmodule
